io_in_unit: RTL and testbench
=============================

IO_IN_UNIT -- requirements
Module: io_in_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 16, word-FIFO entries; power of two, >=2.
REQ-002 SHALL have clk  input  1  the single clock; all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have rx_valid  input  1  one-cycle pulse; a received UART byte is present on rx_data.
REQ-005 SHALL have rx_data  input  8  received byte.
REQ-006 SHALL have in_issued  input  1  one-cycle pulse from decode when an in instruction issues.
REQ-007 SHALL have in_data  output  32  word delivered to the write-back stage.
REQ-008 SHALL have in_stall  output  1  fetch/decode stall request while an in request waits for data.
REQ-009 SHALL have overflow  output  1  sticky flag; a completed word was dropped because the FIFO was full.
REQ-010 SHALL have level  output  $clog2(DEPTH)+1  current number of words held in the FIFO.

Function
REQ-011 SHALL assemble bytes little-endian: the 1st byte after reset or after a completed word goes to [7:0], the 2nd to [15:8], the 3rd to [23:16], the 4th to [31:24].
REQ-012 SHALL track assembly with a 2-bit byte counter that increments on each rx_valid and wraps from 3 to 0 when a word completes.
REQ-013 SHALL push the completed word into the FIFO on the same edge that latches the 4th byte.
REQ-014 SHALL form a request term req = in_issued | pending.
REQ-015 SHALL pop when req=1 and level!=0, where level is sampled before the edge; the popped word appears on in_data from the next cycle.
REQ-016 SHALL hold in_data stable until the next pop.
REQ-017 SHALL drive in_stall combinationally as req & (level==0), so in_stall can assert in the same cycle as in_issued.
REQ-018 SHALL set pending when in_issued=1 and level==0, and clear pending on the pop edge.
REQ-019 SHALL treat in_issued asserted while pending=1 as the same outstanding request (no double pop).
REQ-020 SHALL make a push into an empty FIFO poppable only from the following cycle; there is no same-cycle bypass, so in_stall stays high for that cycle.
REQ-021 SHALL accept the push when the FIFO is full and a pop occurs in the same cycle; level is unchanged in that case.
REQ-022 SHALL drop a completed word that arrives when the FIFO is full with no pop, set overflow, and still return the byte counter to 0.
REQ-023 SHALL keep the pointers free-running modulo DEPTH so wrap-around is transparent to the output ordering.
REQ-024 SHALL clear overflow only on rst.

Reset
REQ-025 SHALL, on rst=1 at a rising edge, clear: byte counter=0, partial word=0, FIFO pointers=0, level=0, pending=0, in_data=32'h0, overflow=0.
REQ-026 SHALL give rst priority over simultaneous rx_valid or in_issued, discarding any partial word and any outstanding request.
REQ-027 SHALL drive in_stall=0 during and immediately after reset.

Structure
REQ-028 SHALL place IN_FIFO_DEPTH_DEFAULT and the 32-bit word typedef in shared package io_pkg.
REQ-029 SHALL implement storage in one sub-module, word_fifo (synchronous FIFO with push, pop, full, empty, count).
REQ-030 SHALL keep the byte assembler, request/pending logic and output register in io_in_unit.

Verification
REQ-031 SHALL verify basic delivery: bytes 0x78,0x56,0x34,0x12 on rx, then in_issued -> in_data=0x12345678 one cycle later; in_stall stays 0 throughout.
REQ-032 SHALL verify stall-then-fill: in_issued with the FIFO empty -> in_stall=1 in that cycle and held until 4 bytes arrive plus one cycle; then in_data=the word and in_stall=0.
REQ-033 SHALL verify overflow: fill DEPTH words, send 4 more bytes with no in_issued -> overflow=1 and level=DEPTH; DEPTH pops then return the first DEPTH words in order.
REQ-034 SHALL verify full push+pop: with level=DEPTH, a 4th byte and in_issued in the same cycle -> no overflow, level stays DEPTH, and the new word is delivered last.
REQ-035 SHALL verify reset mid-operation: 2 bytes received, pending=1, then rst -> in_stall=0 and level=0; a fresh 4 bytes assemble as a new word from [7:0].
REQ-036 SHALL verify wrap-around: stream 3*DEPTH words with interleaved pops -> output sequence equals input sequence.

Source files
------------

// File: rtl/io_pkg.sv
// Shared IO definitions: default input FIFO depth and the 32-bit word type.
package io_pkg;
  localparam int IN_FIFO_DEPTH_DEFAULT = 16;

  typedef logic [31:0] word_t;
endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO with free-running pointers. A push into a full FIFO
// is accepted only when a pop happens on the same edge.
module word_fifo
  import io_pkg::*;
#(
  parameter int DEPTH = IN_FIFO_DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  word_t       push_data,
  input  logic        pop,
  output word_t       head,
  output logic        full,
  output logic        empty,
  output logic [AW:0] count
);

  word_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop_en;
  logic          wr_en;

  assign empty  = (count == '0);
  assign full   = (count == (AW+1)'(DEPTH));
  assign pop_en = pop & ~empty;
  assign wr_en  = push & (~full | pop_en);
  assign head   = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_in_unit.sv
// UART-byte to 32-bit word input unit: assembles little-endian words, queues
// them, and serves 'in' instructions, stalling decode while no word is ready.
module io_in_unit
  import io_pkg::*;
#(
  parameter int DEPTH = IN_FIFO_DEPTH_DEFAULT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        in_issued,
  output word_t       in_data,
  output logic        in_stall,
  output logic        overflow,
  output logic [AW:0] level
);

  logic [1:0] byte_cnt;
  word_t      partial;
  logic       pending;
  logic       req;
  logic       do_pop;
  logic       word_done;
  word_t      fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  word_t      new_word;

  // A repeated in_issued while pending is the same request, so OR is enough.
  assign req       = in_issued | pending;
  assign do_pop    = req & ~fifo_empty;
  assign in_stall  = req & fifo_empty & ~rst;
  assign word_done = rx_valid & (byte_cnt == 2'd3);
  assign new_word  = {rx_data, partial[23:0]};

  word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (word_done),
    .push_data (new_word),
    .pop       (do_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (level)
  );

  // Byte assembler: lane chosen by byte_cnt, partial cleared once a word is done.
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= '0;
      partial  <= '0;
    end else if (rx_valid) begin
      byte_cnt <= byte_cnt + 1'b1;
      if (word_done) partial <= '0;
      else           partial[8*byte_cnt +: 8] <= rx_data;
    end
  end

  // Request tracking, output register, and sticky drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= 1'b0;
      in_data  <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_pop) begin
        pending <= 1'b0;
        in_data <= fifo_head;
      end else if (in_issued) begin
        pending <= 1'b1;
      end
      if (word_done & fifo_full & ~do_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_in_unit.sv
// Self-checking bench for io_in_unit against a queue-based reference model.
module tb_io_in_unit;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic        clk = 0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        in_issued;
  logic [31:0] in_data;
  logic        in_stall;
  logic        overflow;
  logic [AW:0] level;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] q[$];
  logic [7:0]  bbuf[$];
  bit          m_pend;
  logic [31:0] m_data;
  bit          m_ovf;
  logic [31:0] last_word;

  io_in_unit #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .in_issued(in_issued), .in_data(in_data), .in_stall(in_stall),
    .overflow(overflow), .level(level)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete(); bbuf.delete();
    m_pend = 0; m_data = '0; m_ovf = 0;
  endtask

  // One clock of stimulus; checks stall before the edge, registers after.
  task automatic step(input bit rxv, input logic [7:0] rxd, input bit iss);
    bit req, pop;
    int sz;
    @(negedge clk);
    rx_valid = rxv; rx_data = rxd; in_issued = iss;
    #1;
    sz  = q.size();
    req = iss | m_pend;
    pop = req && (sz > 0);
    n_checks++;
    if (in_stall !== (req && sz == 0)) begin
      n_fail++;
      $display("FAIL stall: got %b want %b t=%0t", in_stall, (req && sz == 0), $time);
    end
    @(posedge clk);
    if (pop) begin m_data = q.pop_front(); m_pend = 0; end
    else if (iss) m_pend = 1;
    if (rxv) begin
      bbuf.push_back(rxd);
      if (bbuf.size() == 4) begin
        last_word = {bbuf[3], bbuf[2], bbuf[1], bbuf[0]};
        if (sz == DEPTH && !pop) m_ovf = 1;
        else q.push_back(last_word);
        bbuf.delete();
      end
    end
    #1;
    n_checks++;
    if (in_data !== m_data) begin
      n_fail++;
      $display("FAIL in_data: got %h want %h t=%0t", in_data, m_data, $time);
    end
    n_checks++;
    if (level !== (AW+1)'(q.size())) begin
      n_fail++;
      $display("FAIL level: got %0d want %0d t=%0t", level, q.size(), $time);
    end
    n_checks++;
    if (overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL overflow: got %b want %b t=%0t", overflow, m_ovf, $time);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit iss_last);
    for (int i = 0; i < 4; i++) step(1'b1, w[8*i +: 8], (i == 3) ? iss_last : 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // Reset with random concurrent traffic; rst must win.
  task automatic do_reset();
    @(negedge clk);
    rst = 1; rx_valid = 1'($urandom); rx_data = 8'($urandom); in_issued = 1;
    #1;
    n_checks++;
    if (in_stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_in_reset: got %b want 0", in_stall);
    end
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 0; rx_valid = 0; in_issued = 0;
    #1;
    n_checks++;
    if (in_stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_after_reset: got %b want 0", in_stall);
    end
  endtask

  task automatic test_reset();
    rst = 1; rx_valid = 0; rx_data = 0; in_issued = 0;
    repeat (2) @(posedge clk);
    do_reset();
    n_checks++;
    if (in_data !== 32'h0 || level !== '0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: data=%h level=%0d ovf=%b want 0/0/0", in_data, level, overflow);
    end
  endtask

  task automatic test_basic();
    step(1, 8'h78, 0); step(1, 8'h56, 0); step(1, 8'h34, 0); step(1, 8'h12, 0);
    step(0, 8'h00, 1);
    n_checks++;
    if (in_data !== 32'h12345678) begin
      n_fail++; $display("FAIL basic: got %h want 12345678", in_data);
    end
    idle(2);
  endtask

  task automatic test_stall_fill();
    logic [31:0] w;
    w = $urandom;
    step(0, 8'h00, 1);
    for (int i = 0; i < 4; i++) step(1'b1, w[8*i +: 8], 1'b0);
    step(0, 8'h00, 0);
    n_checks++;
    if (in_data !== w || in_stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_fill: got %h stall=%b want %h stall=0", in_data, in_stall, w);
    end
    idle(1);
  endtask

  task automatic test_overflow();
    logic [31:0] saved[DEPTH];
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      saved[i] = $urandom;
      send_word(saved[i], 0);
    end
    send_word($urandom, 0);
    n_checks++;
    if (overflow !== 1'b1 || level !== (AW+1)'(DEPTH)) begin
      n_fail++; $display("FAIL overflow_set: ovf=%b level=%0d want 1/%0d", overflow, level, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 8'h00, 1);
      n_checks++;
      if (in_data !== saved[i]) begin
        n_fail++; $display("FAIL overflow_order[%0d]: got %h want %h", i, in_data, saved[i]);
      end
    end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] nw;
    do_reset();
    for (int i = 0; i < DEPTH; i++) send_word($urandom, 0);
    nw = $urandom;
    send_word(nw, 1);
    n_checks++;
    if (overflow !== 1'b0 || level !== (AW+1)'(DEPTH)) begin
      n_fail++; $display("FAIL full_push_pop: ovf=%b level=%0d want 0/%0d", overflow, level, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) step(0, 8'h00, 1);
    n_checks++;
    if (in_data !== nw) begin
      n_fail++; $display("FAIL full_push_pop_last: got %h want %h", in_data, nw);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w;
    do_reset();
    step(1, 8'hAA, 0); step(1, 8'hBB, 0);
    step(0, 8'h00, 1);
    do_reset();
    n_checks++;
    if (level !== '0 || in_stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: level=%0d stall=%b want 0/0", level, in_stall);
    end
    w = $urandom;
    send_word(w, 0);
    step(0, 8'h00, 1);
    n_checks++;
    if (in_data !== w) begin
      n_fail++; $display("FAIL reset_mid_word: got %h want %h", in_data, w);
    end
  endtask

  task automatic test_wrap();
    int budget;
    do_reset();
    for (int i = 0; i < 3 * DEPTH; i++) begin
      logic [31:0] w;
      w = $urandom;
      for (int b = 0; b < 4; b++)
        step(1'b1, w[8*b +: 8], ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) step(0, 8'h00, 1);
    end
    budget = 4 * DEPTH;
    while ((q.size() != 0 || m_pend) && budget > 0) begin
      step(0, 8'h00, 1);
      budget--;
    end
    n_checks++;
    if (q.size() != 0 || level !== '0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL wrap_drain: level=%0d ovf=%b want 0/0", level, overflow);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_fill();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
